// File: rtl/rule110_pkg.sv
// Shared constants and state encoding for the Rule 110 block scanner.
package rule110_pkg;

    localparam int CELLS_PER_BLOCK = 8;
    localparam int NUM_CELLS       = 240;
    localparam int NUM_BLOCKS      = NUM_CELLS / CELLS_PER_BLOCK;
    localparam int ADDR_W          = 5;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SEND,
        STEP
    } scan_state_t;

endpackage

// File: rtl/rule110_scanner_if.sv
// Automaton pin bus plus byte stream handshake seen by the scanner.
interface rule110_scanner_if #(
    parameter int ADDR_W = 5,
    parameter int GEN_W  = 16
);

    logic              start;
    logic              run;
    logic [7:0]        ca_data;
    logic [ADDR_W-1:0] ca_addr;
    logic              ca_halt_n;
    logic              ca_we_n;
    logic [7:0]        m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;
    logic [GEN_W-1:0]  gen_count;
    logic              busy;

    modport master (
        input  start,
        input  run,
        input  ca_data,
        input  m_ready,
        output ca_addr,
        output ca_halt_n,
        output ca_we_n,
        output m_data,
        output m_valid,
        output m_last,
        output gen_count,
        output busy
    );

    modport slave (
        output start,
        output run,
        output ca_data,
        output m_ready,
        input  ca_addr,
        input  ca_halt_n,
        input  ca_we_n,
        input  m_data,
        input  m_valid,
        input  m_last,
        input  gen_count,
        input  busy
    );

endinterface

// File: rtl/rule110_scanner.sv
// Scans every block of a halted Rule 110 automaton out as a byte
// stream, then releases the automaton for exactly one generation step.
module rule110_scanner #(
    parameter int NUM_BLOCKS    = rule110_pkg::NUM_BLOCKS,
    parameter int ADDR_W        = rule110_pkg::ADDR_W,
    parameter int SETTLE_CYCLES = 1,
    parameter int GEN_W         = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    rule110_scanner_if.master   bus
);

    import rule110_pkg::*;

    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(NUM_BLOCKS - 1);
    localparam logic [3:0]        RELOAD = 4'(SETTLE_CYCLES);

    scan_state_t       state;
    scan_state_t       state_n;
    logic [3:0]        cnt;
    logic [3:0]        cnt_n;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_n;
    logic [7:0]        data;
    logic [7:0]        data_n;
    logic              valid;
    logic              valid_n;
    logic [GEN_W-1:0]  gen;
    logic [GEN_W-1:0]  gen_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            addr  <= '0;
            data  <= '0;
            valid <= 1'b0;
            gen   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            addr  <= addr_n;
            data  <= data_n;
            valid <= valid_n;
            gen   <= gen_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        addr_n  = addr;
        data_n  = data;
        valid_n = valid;
        gen_n   = gen;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    addr_n  = '0;
                    cnt_n   = RELOAD;
                    state_n = SETTLE;
                end
            end
            SETTLE: begin
                cnt_n = cnt - 4'd1;
                // Sample on the last wait cycle so the pins have settled
                if (cnt == 4'd1) begin
                    data_n  = bus.ca_data;
                    valid_n = 1'b1;
                    state_n = SEND;
                end
            end
            SEND: begin
                if (valid && bus.m_ready) begin
                    valid_n = 1'b0;
                    if (addr == LAST) begin
                        state_n = STEP;
                    end else begin
                        addr_n  = addr + 1'b1;
                        cnt_n   = RELOAD;
                        state_n = SETTLE;
                    end
                end
            end
            STEP: begin
                gen_n = gen + 1'b1;
                if (bus.run) begin
                    addr_n  = '0;
                    cnt_n   = RELOAD;
                    state_n = SETTLE;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.ca_addr   = addr;
    assign bus.ca_halt_n = (state == STEP);
    assign bus.ca_we_n   = 1'b1;
    assign bus.m_data    = data;
    assign bus.m_valid   = valid;
    assign bus.m_last    = valid && (addr == LAST);
    assign bus.gen_count = gen;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_rule110_scanner.sv
// Directed bench: behavioural Rule 110 automaton drives the pins, a
// generation-level scoreboard checks every presented byte.
module tb_rule110_scanner;

    import rule110_pkg::*;

    localparam logic [7:0]           RULE = 8'd110;
    localparam logic [NUM_CELLS-1:0] SEED = NUM_CELLS'(1);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    rule110_scanner_if #(.ADDR_W(5), .GEN_W(16)) bus ();
    rule110_scanner_if #(.ADDR_W(5), .GEN_W(2))  bus2 ();

    rule110_scanner #(
        .NUM_BLOCKS(30), .ADDR_W(5), .SETTLE_CYCLES(1), .GEN_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    rule110_scanner #(
        .NUM_BLOCKS(30), .ADDR_W(5), .SETTLE_CYCLES(1), .GEN_W(2)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // Cell i sees cell i+1 on its left and cell i-1 on its right, wrapping
    function automatic logic [NUM_CELLS-1:0] rule_step(
        input logic [NUM_CELLS-1:0] c);
        logic [NUM_CELLS-1:0] r;
        logic [2:0] p;
        r = '0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            p = {c[(i + 1) % NUM_CELLS], c[i],
                 c[(i + NUM_CELLS - 1) % NUM_CELLS]};
            r[i] = RULE[p];
        end
        return r;
    endfunction

    // The automaton presents its next row on its pins and commits it
    // on any edge where halt is released.
    logic [NUM_CELLS-1:0] cells;
    logic [NUM_CELLS-1:0] row;

    always @(posedge clk) begin
        if (!rst_n) cells <= SEED;
        else if (bus.ca_halt_n) cells <= rule_step(cells);
    end

    always_comb row = rule_step(cells);

    assign bus.ca_data = (bus.ca_addr < 5'd30) ?
                         row[{bus.ca_addr, 3'b000} +: 8] : 8'h00;
    assign bus2.ca_data = {3'b000, bus2.ca_addr};

    int idx = 0;
    int n_bytes = 0;
    int n_halt = 0;
    int n_busy = 0;
    int n_last = 0;
    int n_nz = 0;
    logic [NUM_CELLS-1:0] exp_row;
    logic [7:0] firsts[$];

    always @(posedge clk) begin
        if (!rst_n) begin
            idx     <= 0;
            exp_row <= rule_step(SEED);
        end else begin
            if (bus.ca_halt_n) n_halt <= n_halt + 1;
            if (bus.busy) n_busy <= n_busy + 1;
            if (bus.m_valid && bus.m_ready) begin
                n_bytes <= n_bytes + 1;
                if (bus.m_last) n_last <= n_last + 1;
                if (idx == 0) firsts.push_back(bus.m_data);
                else if (bus.m_data != 8'h00) n_nz <= n_nz + 1;
                if (idx == NUM_BLOCKS - 1) begin
                    idx     <= 0;
                    exp_row <= rule_step(exp_row);
                end else begin
                    idx <= idx + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("we_n", 32'(bus.ca_we_n), 1);
            chk("addr_range", 32'(bus.ca_addr <= 5'd29), 1);
            if (bus.m_valid) begin
                chk("m_data", 32'(bus.m_data), 32'(exp_row[idx*8 +: 8]));
                chk("ca_addr", 32'(bus.ca_addr), idx);
                chk("m_last", 32'(bus.m_last), 32'(idx == 29));
                chk("halt_in_send", 32'(bus.ca_halt_n), 0);
            end else begin
                chk("m_last_low", 32'(bus.m_last), 0);
            end
        end
    end

    int b0, h0, bz0, l0, z0, f0;
    logic [7:0] held;
    logic [1:0] gexp[5];

    task automatic snap();
        b0  = n_bytes;
        h0  = n_halt;
        bz0 = n_busy;
        l0  = n_last;
        z0  = n_nz;
        f0  = firsts.size();
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000 && bus.busy; i++) @(negedge clk);
        chk("idle_timeout", 32'(bus.busy), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.run      = 1'b0;
        bus.m_ready  = 1'b1;
        bus2.start   = 1'b0;
        bus2.run     = 1'b0;
        bus2.m_ready = 1'b1;
        gexp[0] = 2'd1;
        gexp[1] = 2'd2;
        gexp[2] = 2'd3;
        gexp[3] = 2'd0;
        gexp[4] = 2'd1;

        repeat (3) @(negedge clk);
        chk("rst_addr", 32'(bus.ca_addr), 0);
        chk("rst_halt", 32'(bus.ca_halt_n), 0);
        chk("rst_we", 32'(bus.ca_we_n), 1);
        chk("rst_data", 32'(bus.m_data), 0);
        chk("rst_valid", 32'(bus.m_valid), 0);
        chk("rst_last", 32'(bus.m_last), 0);
        chk("rst_gen", 32'(bus.gen_count), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // single pass
        snap();
        pulse_start();
        wait_idle();
        chk("p1_bytes", n_bytes - b0, 30);
        chk("p1_last", n_last - l0, 1);
        chk("p1_halt", n_halt - h0, 1);
        chk("p1_gen", 32'(bus.gen_count), 1);
        chk("p1_cycles", n_busy - bz0, 61);
        chk("p1_first", 32'(firsts[f0]), 32'h03);
        chk("p1_rest_zero", n_nz - z0, 0);

        // stall on block 3
        snap();
        pulse_start();
        for (int i = 0; i < 200 && !(bus.m_valid && bus.ca_addr == 5'd3); i++)
            @(negedge clk);
        chk("blk3_timeout", 32'(bus.m_valid && bus.ca_addr == 5'd3), 1);
        bus.m_ready = 1'b0;
        held = bus.m_data;
        chk("blk3_gen2", 32'(held), 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_data", 32'(bus.m_data), 32'(held));
            chk("hold_addr", 32'(bus.ca_addr), 3);
            chk("hold_valid", 32'(bus.m_valid), 1);
            chk("hold_halt", 32'(bus.ca_halt_n), 0);
        end
        bus.m_ready = 1'b1;
        wait_idle();
        chk("p2_bytes", n_bytes - b0, 30);
        chk("p2_halt", n_halt - h0, 1);
        chk("p2_gen", 32'(bus.gen_count), 2);
        chk("p2_first", 32'(firsts[f0]), 32'h07);

        // three back-to-back passes, run dropped mid third pass
        do_reset();
        chk("r3_gen", 32'(bus.gen_count), 0);
        snap();
        bus.run = 1'b1;
        pulse_start();
        for (int i = 0; i < 400 && (n_halt - h0) < 2; i++) @(negedge clk);
        chk("run_timeout", n_halt - h0, 2);
        for (int i = 0; i < 100 && !(bus.busy && bus.ca_addr == 5'd5); i++)
            @(negedge clk);
        bus.run = 1'b0;
        wait_idle();
        chk("run_bytes", n_bytes - b0, 90);
        chk("run_halt", n_halt - h0, 3);
        chk("run_last", n_last - l0, 3);
        chk("run_gen", 32'(bus.gen_count), 3);
        chk("run_g1", 32'(firsts[f0]), 32'h03);
        chk("run_g2", 32'(firsts[f0 + 1]), 32'h07);
        chk("run_g3", 32'(firsts[f0 + 2]), 32'h0D);

        // start while busy is ignored
        snap();
        pulse_start();
        for (int i = 0; i < 200 &&
             !(bus.busy && !bus.m_valid && bus.ca_addr == 5'd10); i++)
            @(negedge clk);
        chk("blk10_timeout", 32'(bus.ca_addr), 10);
        pulse_start();
        wait_idle();
        repeat (10) @(negedge clk);
        chk("ign_busy", 32'(bus.busy), 0);
        chk("ign_bytes", n_bytes - b0, 30);
        chk("ign_halt", n_halt - h0, 1);
        chk("ign_gen", 32'(bus.gen_count), 4);

        // reset with a pending byte on block 7
        snap();
        pulse_start();
        for (int i = 0; i < 200 && !(bus.m_valid && bus.ca_addr == 5'd7); i++)
            @(negedge clk);
        chk("blk7_timeout", 32'(bus.ca_addr), 7);
        bus.m_ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mr_valid", 32'(bus.m_valid), 0);
        chk("mr_addr", 32'(bus.ca_addr), 0);
        chk("mr_busy", 32'(bus.busy), 0);
        chk("mr_gen", 32'(bus.gen_count), 0);
        chk("mr_last", 32'(bus.m_last), 0);
        rst_n = 1'b1;
        bus.m_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("mr_no_step", n_halt - h0, 0);
        chk("mr_idle", 32'(bus.busy), 0);

        // narrow generation counter wraps
        bus2.run = 1'b1;
        bus2.start = 1'b1;
        @(negedge clk);
        bus2.start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 200 && !bus2.ca_halt_n; i++) @(negedge clk);
            chk("g2_step_timeout", 32'(bus2.ca_halt_n), 1);
            @(negedge clk);
            chk("g2_gen", 32'(bus2.gen_count), 32'(gexp[k]));
            if (k == 3) bus2.run = 1'b0;
        end
        for (int i = 0; i < 200 && bus2.busy; i++) @(negedge clk);
        chk("g2_idle", 32'(bus2.busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
